// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported instruction/data memory between the
// fetch path and the load/store path. Accesses are serialised through a
// small FSM. Contention is resolved round-robin, and each requester gets
// registered read data plus a one-cycle completion pulse.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_done,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_en,
  output logic [3:0]      mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, WAIT} state_t;
  typedef enum logic {GR_I, GR_D} grant_t;

  state_t          state_q;
  grant_t          last_grant_q;
  logic            store_q;
  logic [3:0]      cnt_q;
  logic            mem_en_q;
  logic [3:0]      mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [XLEN-1:0] if_rdata_q;
  logic [XLEN-1:0] d_rdata_q;
  logic            if_done_q;
  logic            d_done_q;

  logic f_pend;
  logic d_pend;

  // Pending requests; masking with done stops a re-issue while the requester drops its level.
  always_comb begin
    f_pend = if_req & ~if_done_q;
    d_pend = (d_read | d_write) & ~d_done_q;
  end

  // Access sequencer: grant, issue strobe, latency countdown, capture and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GR_D;
      store_q      <= 1'b0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= XLEN'(32'h0000_0013);
      d_rdata_q    <= '0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (f_pend && (!d_pend || last_grant_q == GR_D)) begin
            mem_addr_q   <= if_addr;
            mem_we_q     <= '0;
            mem_en_q     <= 1'b1;
            last_grant_q <= GR_I;
            state_q      <= ACC_I;
          end else if (d_pend) begin
            mem_addr_q   <= d_addr;
            mem_wdata_q  <= d_wdata;
            mem_we_q     <= d_write ? d_wstrb : 4'b0000;
            store_q      <= d_write;
            mem_en_q     <= 1'b1;
            last_grant_q <= GR_D;
            state_q      <= ACC_D;
          end
        end
        ACC_I, ACC_D: begin
          mem_en_q <= 1'b0;
          mem_we_q <= '0;
          cnt_q    <= 4'(MEM_LATENCY - 1);
          state_q  <= WAIT;
        end
        WAIT: begin
          // cnt reaches zero in the cycle mem_rdata is valid (issue + MEM_LATENCY).
          if (cnt_q == 4'd0) begin
            if (last_grant_q == GR_I) begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              if (!store_q) d_rdata_q <= mem_rdata;
              d_done_q <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign stall_if  = f_pend;
  assign stall_mem = d_pend;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: latency-1 and latency-3 instances
// share stimulus, each fed by a memory model that drives valid read data only
// MEM_LATENCY cycles after its mem_en.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata, resp;
  logic [3:0]  d_wstrb;

  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_done1, d_done1, stall_if1, stall_mem1, mem_en1;
  logic [3:0]  mem_we1;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        if_done3, d_done3, stall_if3, stall_mem3, mem_en3;
  logic [3:0]  mem_we3;

  logic        hist1 = 1'b0;
  logic [2:0]  hist3 = 3'b000;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.MEM_LATENCY(1), .XLEN(32)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1),
    .if_done(if_done1), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata1), .d_done(d_done1),
    .stall_if(stall_if1), .stall_mem(stall_mem1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .XLEN(32)) u3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3),
    .if_done(if_done3), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata3), .d_done(d_done3),
    .stall_if(stall_if3), .stall_mem(stall_mem3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Memory models: data valid exactly MEM_LATENCY cycles after the strobe.
  always @(posedge clk) begin
    hist1 <= mem_en1;
    hist3 <= {hist3[1:0], mem_en3};
  end
  assign mem_rdata1 = hist1    ? resp : 32'hBAD0_0BAD;
  assign mem_rdata3 = hist3[2] ? resp : 32'hBAD0_0BAD;

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic        dw;
    logic [31:0] da;  logic [31:0] dwd; logic [3:0] ws; logic [31:0] rs;
    logic        en;  logic [3:0]  we;  logic [31:0] ma; logic [31:0] mwd;
    logic        idn; logic        ddn; logic sif; logic smem;
    logic [31:0] ird; logic [31:0] drd;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                              input logic [3:0] ws, input logic [31:0] rs, input logic en,
                              input logic [3:0] we, input logic [31:0] ma,
                              input logic [31:0] mwd, input logic idn, input logic ddn,
                              input logic sif, input logic smem, input logic [31:0] ird,
                              input logic [31:0] drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ws = ws;
    v.rs = rs; v.en = en; v.we = we; v.ma = ma; v.mwd = mwd; v.idn = idn; v.ddn = ddn;
    v.sif = sif; v.smem = smem; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int en_cnt, en_cyc, dn_cnt, dn_cyc;

  initial begin
    rst = 1'b1; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; resp = '0;

    // Cycle-by-cycle vectors, latency 1: a fetch then a store.
    //          ir ia         dr dw da         dwd           ws    rs            | en we     ma         mwd           idn ddn sif sm ird           drd
    vt[0] = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,        4'h0, 32'h00500093, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h13,       32'h0);
    vt[1] = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,        4'h0, 32'h00500093, 1, 4'h0, 32'h100,  32'h0,        0, 0, 1, 0, 32'h13,       32'h0);
    vt[2] = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,        4'h0, 32'h00500093, 0, 4'h0, 32'h100,  32'h0,        0, 0, 1, 0, 32'h13,       32'h0);
    vt[3] = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,        4'h0, 32'h00500093, 0, 4'h0, 32'h100,  32'h0,        1, 0, 0, 0, 32'h00500093, 32'h0);
    vt[4] = mk(0, 32'h100,   0, 0, 32'h0,    32'h0,        4'h0, 32'h00500093, 0, 4'h0, 32'h100,  32'h0,        0, 0, 0, 0, 32'h00500093, 32'h0);
    vt[5] = mk(0, 32'h100,   0, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 32'hCAFEF00D, 0, 4'h0, 32'h100,  32'h0,        0, 0, 0, 1, 32'h00500093, 32'h0);
    vt[6] = mk(0, 32'h100,   0, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 32'hCAFEF00D, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 1, 32'h00500093, 32'h0);
    vt[7] = mk(0, 32'h100,   0, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 32'hCAFEF00D, 0, 4'h0, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 1, 32'h00500093, 32'h0);
    vt[8] = mk(0, 32'h100,   0, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 32'hCAFEF00D, 0, 4'h0, 32'h2004, 32'hDEADBEEF, 0, 1, 0, 0, 32'h00500093, 32'h0);
    vt[9] = mk(0, 32'h100,   0, 0, 32'h2004, 32'hDEADBEEF, 4'h3, 32'hCAFEF00D, 0, 4'h0, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0, 32'h00500093, 32'h0);

    do_reset();
    #1;
    chk("reset_state",
        {mem_en1, mem_we1, mem_addr1, mem_wdata1, if_done1, d_done1, if_rdata1, d_rdata1},
        {1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h13, 32'h0});
    chk("reset_state_l3", {mem_en3, if_rdata3, d_rdata3, d_done3}, {1'b0, 32'h13, 32'h0, 1'b0});

    for (int i = 0; i < 10; i++) begin
      if_req = vt[i].ir; if_addr = vt[i].ia; d_read = vt[i].dr; d_write = vt[i].dw;
      d_addr = vt[i].da; d_wdata = vt[i].dwd; d_wstrb = vt[i].ws; resp = vt[i].rs;
      #1;
      chk($sformatf("vec%0d", i),
          {mem_en1, mem_we1, mem_addr1, mem_wdata1, if_done1, d_done1, stall_if1, stall_mem1,
           if_rdata1, d_rdata1},
          {vt[i].en, vt[i].we, vt[i].ma, vt[i].mwd, vt[i].idn, vt[i].ddn, vt[i].sif, vt[i].smem,
           vt[i].ird, vt[i].drd});
      step();
    end

    // Contention right after reset: fetch first, load granted in the if_done cycle.
    do_reset();
    if_req = 1'b1; if_addr = 32'h104; d_read = 1'b1; d_addr = 32'h500; resp = 32'hF0F0_0001;
    #1;
    chk("cont_stalls", {stall_if1, stall_mem1}, 2'b11);
    step();
    chk("cont_fetch_first", {mem_en1, mem_addr1}, {1'b1, 32'h104});
    step();
    step();
    chk("cont_if_done", {if_done1, d_done1, stall_mem1, if_rdata1}, {1'b1, 1'b0, 1'b1, 32'hF0F0_0001});
    if_req = 1'b0; resp = 32'h1111_2222;
    step();
    chk("cont_load_issue", {mem_en1, mem_we1, mem_addr1}, {1'b1, 4'h0, 32'h500});
    step();
    step();
    chk("cont_d_done", {d_done1, if_done1, d_rdata1}, {1'b1, 1'b0, 32'h1111_2222});
    d_read = 1'b0;
    step();
    // A lone fetch leaves last_grant at fetch, so the next contention goes to data.
    if_req = 1'b1; if_addr = 32'h108; resp = 32'h0000_0108;
    step();
    step();
    step();
    chk("lone_fetch_done", {if_done1, if_rdata1}, {1'b1, 32'h0000_0108});
    if_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h10C; d_read = 1'b1; d_addr = 32'h600; resp = 32'h0000_0600;
    step();
    chk("cont2_data_first", {mem_en1, mem_addr1}, {1'b1, 32'h600});
    step();
    step();
    chk("cont2_d_done", {d_done1, d_rdata1}, {1'b1, 32'h0000_0600});
    d_read = 1'b0; resp = 32'h0000_010C;
    step();
    chk("cont2_fetch_next", {mem_en1, mem_addr1}, {1'b1, 32'h10C});
    step();
    step();
    chk("cont2_if_done", {if_done1, if_rdata1}, {1'b1, 32'h0000_010C});
    if_req = 1'b0;
    step();

    // Reset during WAIT of a fetch discards the response.
    if_req = 1'b1; if_addr = 32'h200; resp = 32'h7777_7777;
    step();
    chk("rstw_issue", mem_en1, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rstw_cleared", {mem_en1, if_done1, if_rdata1}, {1'b0, 1'b0, 32'h13});
    step();
    chk("rstw_refetch", {mem_en1, mem_addr1}, {1'b1, 32'h200});
    step();
    step();
    chk("rstw_done", {if_done1, if_rdata1}, {1'b1, 32'h7777_7777});
    if_req = 1'b0;
    step();

    // Address change after grant is ignored; single completion.
    d_read = 1'b1; d_addr = 32'h4000; resp = 32'h4444_0000;
    step();
    d_addr = 32'h9999;
    #1;
    chk("addr_hold_issue", {mem_en1, mem_addr1}, {1'b1, 32'h4000});
    step();
    chk("addr_hold_wait", mem_addr1, 32'h4000);
    step();
    chk("addr_hold_done", {d_done1, d_rdata1}, {1'b1, 32'h4444_0000});
    d_read = 1'b0;
    dn_cnt = 0; en_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (d_done1) dn_cnt++;
      if (mem_en1) en_cnt++;
    end
    chk("addr_hold_single", {dn_cnt, en_cnt}, {32'd0, 32'd0});

    // Latency 3: load at 0x3000, done at t+5, one strobe.
    do_reset();
    d_read = 1'b1; d_addr = 32'h3000; resp = 32'h1234_5678;
    en_cnt = 0; en_cyc = -1; dn_cnt = 0; dn_cyc = -1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (mem_en3) begin
        en_cnt++;
        if (en_cyc < 0) en_cyc = k;
      end
      if (d_done3) begin
        dn_cnt++;
        if (dn_cyc < 0) dn_cyc = k;
        d_read = 1'b0;
      end
    end
    chk("l3_mem_en", {en_cnt, en_cyc}, {32'd1, 32'd1});
    chk("l3_done", {dn_cnt, dn_cyc}, {32'd1, 32'd5});
    chk("l3_rdata", d_rdata3, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
